// File: rtl/reg_writeback_queue.sv
// Register writeback queue: circular FIFO of (addr, data) writes that drains into the
// register bank one per cycle, with newest-wins forwarding over all pending entries.
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_addr,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       stall,
  output logic                       write_enable,
  output logic [4:0]                 write_register_addr,
  output logic [DATA_W-1:0]          write_data,
  input  logic [4:0]                 lookup_addr_1,
  input  logic [4:0]                 lookup_addr_2,
  output logic                       fwd_hit_1,
  output logic [DATA_W-1:0]          fwd_data_1,
  output logic                       fwd_hit_2,
  output logic [DATA_W-1:0]          fwd_data_2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]        addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic store_en;
  logic pop_en;

  assign in_ready     = (count_reg < CNT_W'(DEPTH));
  assign empty        = (count_reg == '0);
  assign count        = count_reg;
  assign write_enable = !empty && !stall;
  assign pop_en       = write_enable;
  // Writes to x0 complete the handshake but are never queued.
  assign store_en     = in_valid && in_ready && (in_addr != 5'd0);

  assign write_register_addr = write_enable ? addr_mem[head_reg] : 5'd0;
  assign write_data          = write_enable ? data_mem[head_reg] : '0;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg + CNT_W'(store_en) - CNT_W'(pop_en);
    if (store_en) tail_next = tail_reg + 1'b1;
    if (pop_en)   head_next = head_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Payload storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (store_en) begin
      addr_mem[tail_reg] <= in_addr;
      data_mem[tail_reg] <= in_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [4:0]        probe;
      logic              hit;
      logic [DATA_W-1:0] hit_data;

      assign probe = (gi == 0) ? lookup_addr_1 : lookup_addr_2;

      // Walk oldest to newest so the last match (newest entry) wins.
      always_comb begin
        logic [PTR_W-1:0] idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
          idx = head_reg + PTR_W'(k);
          if ((CNT_W'(k) < count_reg) && (probe != 5'd0) && (addr_mem[idx] == probe)) begin
            hit      = 1'b1;
            hit_data = data_mem[idx];
          end
        end
      end
    end
  endgenerate

  assign fwd_hit_1  = g_fwd[0].hit;
  assign fwd_data_1 = g_fwd[0].hit_data;
  assign fwd_hit_2  = g_fwd[1].hit;
  assign fwd_data_2 = g_fwd[1].hit_data;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: hand-computed vectors checked with immediate assertions.
module tb_reg_writeback_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        stall;
  logic        write_enable;
  logic [4:0]  write_register_addr;
  logic [31:0] write_data;
  logic [4:0]  lookup_addr_1;
  logic [4:0]  lookup_addr_2;
  logic        fwd_hit_1;
  logic [31:0] fwd_data_1;
  logic        fwd_hit_2;
  logic [31:0] fwd_data_2;
  logic [2:0]  count;
  logic        empty;

  int n_pass  = 0;
  int n_total = 0;

  reg_writeback_queue #(.DEPTH(4), .DATA_W(32)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_addr             (in_addr),
    .in_data             (in_data),
    .stall               (stall),
    .write_enable        (write_enable),
    .write_register_addr (write_register_addr),
    .write_data          (write_data),
    .lookup_addr_1       (lookup_addr_1),
    .lookup_addr_2       (lookup_addr_2),
    .fwd_hit_1           (fwd_hit_1),
    .fwd_data_1          (fwd_data_1),
    .fwd_hit_2           (fwd_hit_2),
    .fwd_data_2          (fwd_data_2),
    .count               (count),
    .empty               (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_set(input logic [4:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_addr  = 5'd0;
    in_data  = 32'd0;
  endtask

  int exp_head;

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    lookup_addr_1 = 5'd0;
    lookup_addr_2 = 5'd0;
    idle();
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_we", write_enable, 0);
    chk("rst_waddr", write_register_addr, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_hit1", fwd_hit_1, 0);
    chk("rst_hit2", fwd_hit_2, 0);
    chk("rst_fdata1", fwd_data_1, 0);
    chk("rst_fdata2", fwd_data_2, 0);

    // Single write; also the first push after reset release.
    tick();
    rst_n = 1'b1;
    push_set(5'd5, 32'd6);
    tick();
    idle();
    settle();
    chk("single_we", write_enable, 1);
    chk("single_addr", write_register_addr, 5);
    chk("single_data", write_data, 6);
    chk("single_count", count, 1);
    tick();
    chk("single_empty", empty, 1);
    chk("single_we_after", write_enable, 0);
    chk("single_addr_after", write_register_addr, 0);

    // Fill under stall, offer one more while full, then drain in order.
    stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push_set(5'(i), 32'(i * 10));
      tick();
    end
    push_set(5'd9, 32'd90);
    settle();
    chk("full_in_ready", in_ready, 0);
    chk("full_count", count, 4);
    chk("full_we_stalled", write_enable, 0);
    tick();
    idle();
    settle();
    chk("full_count_hold", count, 4);
    stall = 1'b0;
    settle();
    chk("drain_we", write_enable, 1);
    chk("drain_addr_1", write_register_addr, 1);
    chk("drain_data_1", write_data, 10);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("drain_we_n", write_enable, 1);
      chk("drain_addr_n", write_register_addr, 32'(i));
      chk("drain_data_n", write_data, 32'(i * 10));
    end
    tick();
    chk("drain_empty", empty, 1);

    // Forwarding priority: newest matching entry wins, including while head drains.
    stall = 1'b1;
    push_set(5'd7, 32'hA);
    tick();
    push_set(5'd7, 32'hB);
    tick();
    idle();
    lookup_addr_1 = 5'd7;
    lookup_addr_2 = 5'd9;
    settle();
    chk("fwd_hit1", fwd_hit_1, 1);
    chk("fwd_data1_newest", fwd_data_1, 32'hB);
    chk("fwd_hit2_miss", fwd_hit_2, 0);
    chk("fwd_data2_miss", fwd_data_2, 0);
    lookup_addr_2 = 5'd7;
    stall = 1'b0;
    settle();
    chk("fwd_head_draining_hit", fwd_hit_2, 1);
    chk("fwd_head_draining_data", fwd_data_2, 32'hB);
    tick();
    chk("fwd_one_left_data", fwd_data_1, 32'hB);
    chk("fwd_one_left_waddr", write_register_addr, 7);
    chk("fwd_one_left_wdata", write_data, 32'hB);
    tick();
    chk("fwd_gone_hit", fwd_hit_1, 0);
    chk("fwd_gone_data", fwd_data_1, 0);
    lookup_addr_1 = 5'd0;
    lookup_addr_2 = 5'd0;

    // x0 writes handshake but are dropped; lookup of x0 never hits.
    push_set(5'd0, 32'hFFFF);
    settle();
    chk("x0_in_ready", in_ready, 1);
    tick();
    idle();
    settle();
    chk("x0_count", count, 0);
    chk("x0_we", write_enable, 0);
    chk("x0_hit1", fwd_hit_1, 0);

    // Push+pop with two pending keeps count; 12 pushes wrap the pointers three times.
    stall = 1'b1;
    push_set(5'd1, 32'd16);
    tick();
    push_set(5'd2, 32'd32);
    tick();
    stall = 1'b0;
    exp_head = 1;
    for (int i = 3; i <= 12; i++) begin
      push_set(5'(i), 32'(i * 16));
      settle();
      chk("wrap_count", count, 2);
      chk("wrap_addr", write_register_addr, 32'(exp_head));
      chk("wrap_data", write_data, 32'(exp_head * 16));
      tick();
      exp_head++;
    end
    idle();
    settle();
    chk("wrap_tail_addr_11", write_register_addr, 11);
    chk("wrap_tail_count", count, 2);
    tick();
    chk("wrap_tail_addr_12", write_register_addr, 12);
    chk("wrap_tail_data_12", write_data, 192);
    tick();
    chk("wrap_empty", empty, 1);

    // Reset asserted between edges while entries are draining.
    stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      push_set(5'(i + 20), 32'(i));
      tick();
    end
    idle();
    stall = 1'b0;
    settle();
    chk("mid_we_before", write_enable, 1);
    chk("mid_count_before", count, 3);
    rst_n = 1'b0;
    settle();
    chk("mid_count_rst", count, 0);
    chk("mid_we_rst", write_enable, 0);
    chk("mid_waddr_rst", write_register_addr, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_we", write_enable, 0);
    chk("post_rst_count", count, 0);
    push_set(5'd5, 32'h55);
    tick();
    idle();
    settle();
    chk("post_rst_push_addr", write_register_addr, 5);
    chk("post_rst_push_data", write_data, 32'h55);
    tick();
    chk("post_rst_empty", empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
